// File: rtl/noc_pkg.sv
// Shared NoC router constants, flit field positions and the output-port FSM state type.
package noc_pkg;
    localparam int NPORT    = 5;
    localparam int FLIT_W   = 35;
    localparam int NVC      = 2;
    localparam int VC_W     = (NVC > 1) ? $clog2(NVC) : 1;
    localparam int PORT_W   = $clog2(NPORT);
    localparam int HEAD_BIT = FLIT_W - 1;
    localparam int TAIL_BIT = FLIT_W - 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic [FLIT_W-1:0] flit_t;

    function automatic logic [PORT_W-1:0] port_inc(input logic [PORT_W-1:0] p);
        return (p == PORT_W'(NPORT - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/noc_out_port_arb_if.sv
// Request/grant bundle from the input ports plus the registered output link of one router output.
interface noc_out_port_arb_if;
    import noc_pkg::*;

    logic [NPORT-1:0]             req_valid;
    logic [NPORT-1:0][VC_W-1:0]   req_vch;
    logic [NPORT-1:0][FLIT_W-1:0] req_data;
    logic [NPORT-1:0]             gnt;
    logic [FLIT_W-1:0]            ODATA;
    logic                         OVALID;
    logic [VC_W-1:0]              OVCH;
    logic [NVC-1:0]               IACK;
    logic [NVC-1:0]               ILCK;
    logic                         err;

    modport slave (
        input  req_valid, req_vch, req_data, IACK, ILCK,
        output gnt, ODATA, OVALID, OVCH, err
    );

    modport master (
        output req_valid, req_vch, req_data, IACK, ILCK,
        input  gnt, ODATA, OVALID, OVCH, err
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward from ptr, wrapping.
module noc_rr_arbiter
    import noc_pkg::*;
(
    input  logic [NPORT-1:0]  req,
    input  logic [PORT_W-1:0] ptr,
    output logic [NPORT-1:0]  gnt,
    output logic [PORT_W-1:0] idx,
    output logic              any
);
    logic [PORT_W-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < NPORT; k++) begin
            cand = PORT_W'((32'(ptr) + k) % NPORT);
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/noc_out_port_arb.sv
// Output-port allocator: round-robin head arbitration, wormhole lock, per-VC credits, registered link.
// Optional NOC_ARB_TIMEOUT_EN adds a stall counter that force-releases a stuck lock.
module noc_out_port_arb
    import noc_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              RST_,
    noc_out_port_arb_if.slave bus
);
    localparam int CW = $clog2(CREDITS + 1);

    if (CREDITS < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("noc_out_port_arb: CREDITS and TIMEOUT must be positive");
    end

    arb_state_t        state, state_nxt;
    logic [PORT_W-1:0] rr_ptr, owner;
    logic [VC_W-1:0]   owner_vc;
    logic [CW-1:0]     credit [NVC];

    logic [NVC-1:0]    cred_ok, cred_dec;
    logic              cred_ovf;
    logic [NPORT-1:0]  elig, arb_gnt, gnt;
    logic [PORT_W-1:0] arb_idx, sel_port;
    logic              arb_any, send, sel_tail, timeout;
    logic [VC_W-1:0]   sel_vc;
    flit_t             sel_flit;

    flit_t             odata;
    logic              ovalid, err;
    logic [VC_W-1:0]   ovch;

    always_comb begin
        cred_dec = '0;
        cred_ok  = '0;
        cred_ovf = 1'b0;
        for (int v = 0; v < NVC; v++) begin
            cred_dec[v] = send && (sel_vc == VC_W'(v));
            cred_ok[v]  = (credit[v] != '0);
            if (bus.IACK[v] && !cred_dec[v] && credit[v] == CW'(CREDITS))
                cred_ovf = 1'b1;
        end
    end

    // Only heads compete; body flits left over from an aborted packet never win.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NPORT; i++)
            elig[i] = bus.req_valid[i] && bus.req_data[i][HEAD_BIT] &&
                      cred_ok[bus.req_vch[i]] && !bus.ILCK[bus.req_vch[i]];
    end

    noc_rr_arbiter u_rr (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (send && !sel_tail)             state_nxt = ARB_BUSY;
            ARB_BUSY: if ((send && sel_tail) || timeout) state_nxt = ARB_IDLE;
            default:                                     state_nxt = ARB_IDLE;
        endcase
    end

    // Mid-packet the owner streams regardless of its req_vch or ILCK.
    always_comb begin
        send     = 1'b0;
        gnt      = '0;
        sel_port = '0;
        sel_vc   = '0;
        case (state)
            ARB_IDLE: if (arb_any) begin
                send     = 1'b1;
                gnt      = arb_gnt;
                sel_port = arb_idx;
                sel_vc   = bus.req_vch[arb_idx];
            end
            ARB_BUSY: if (bus.req_valid[owner] && cred_ok[owner_vc]) begin
                send       = 1'b1;
                gnt[owner] = 1'b1;
                sel_port   = owner;
                sel_vc     = owner_vc;
            end
            default: ;
        endcase
    end

    assign sel_flit = bus.req_data[sel_port];
    assign sel_tail = sel_flit[TAIL_BIT];

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            rr_ptr   <= '0;
            owner    <= '0;
            owner_vc <= '0;
        end else begin
            if (state == ARB_IDLE && send) begin
                owner    <= sel_port;
                owner_vc <= sel_vc;
            end
            if ((send && sel_tail) || timeout)
                rr_ptr <= port_inc(timeout ? owner : sel_port);
        end
    end

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            for (int v = 0; v < NVC; v++) credit[v] <= CW'(CREDITS);
        end else begin
            for (int v = 0; v < NVC; v++) begin
                if (cred_dec[v] && !bus.IACK[v])
                    credit[v] <= credit[v] - 1'b1;
                else if (bus.IACK[v] && !cred_dec[v] && credit[v] != CW'(CREDITS))
                    credit[v] <= credit[v] + 1'b1;
            end
        end
    end

`ifdef NOC_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] stall_cnt;

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_)                                          stall_cnt <= '0;
        else if (state != ARB_BUSY || send || timeout)      stall_cnt <= '0;
        else                                                stall_cnt <= stall_cnt + 1'b1;
    end

    // Fires on the TIMEOUT-th consecutive stalled BUSY cycle.
    assign timeout = (state == ARB_BUSY) && !send && (stall_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
            err    <= 1'b0;
        end else begin
            ovalid <= send;
            if (send) begin
                odata <= sel_flit;
                ovch  <= sel_vc;
            end
            if (cred_ovf || timeout) err <= 1'b1;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.ODATA  = odata;
    assign bus.OVALID = ovalid;
    assign bus.OVCH   = ovch;
    assign bus.err    = err;
endmodule

// File: tb/tb_noc_out_port_arb.sv
// Scoreboard bench: per-port flit sources feed the arbiter, expected link flits are queued in order.
module tb_noc_out_port_arb;
    import noc_pkg::*;

    typedef struct packed {
        logic [FLIT_W-1:0] data;
        logic [VC_W-1:0]   vc;
    } fl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_out_port_arb_if bus();

    noc_out_port_arb #(.CREDITS(4), .TIMEOUT(64)) dut (
        .clk  (clk),
        .RST_ (rst_n),
        .bus  (bus)
    );

    fl_t              src_q [NPORT][$];
    fl_t              exp_q [$];
    logic [NPORT-1:0] src_en;
    logic [NPORT-1:0] gnt_s;
    int               n_chk = 0;
    int               n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NPORT; i++) begin
            if (src_en[i] && src_q[i].size() > 0) begin
                bus.req_valid[i] = 1'b1;
                bus.req_data[i]  = src_q[i][0].data;
                bus.req_vch[i]   = src_q[i][0].vc;
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_data[i]  = '0;
                bus.req_vch[i]   = '0;
            end
        end
    endtask

    // hmask bit j puts the head bit on flit j; the last flit always carries tail.
    task automatic push_pkt(input int p, input int vc, input int len, input int tag,
                            input int hmask, input bit expect_out);
        fl_t f;
        for (int j = 0; j < len; j++) begin
            f.data = {hmask[j], 1'(j == len - 1), 33'(p * 256 + tag * 16 + j)};
            f.vc   = VC_W'(vc);
            src_q[p].push_back(f);
            if (expect_out) exp_q.push_back(f);
        end
    endtask

    task automatic step();
        fl_t e;
        @(negedge clk);
        gnt_s = bus.gnt;
        if (gnt_s != '0) begin
            chk("gnt_onehot", 64'($onehot(gnt_s)), 64'd1);
            chk("gnt_no_req", 64'(gnt_s & ~bus.req_valid), 64'd0);
        end
        if (bus.OVALID) begin
            if (exp_q.size() == 0) begin
                chk("ovalid_unexp", 64'(bus.OVALID), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("odata", 64'(bus.ODATA), 64'(e.data));
                chk("ovch", 64'(bus.OVCH), 64'(e.vc));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NPORT; i++)
            if (gnt_s[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic flush();
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) step();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    task automatic do_reset();
        bus.IACK = '0;
        bus.ILCK = '0;
        src_en   = '1;
        for (int i = 0; i < NPORT; i++) src_q[i].delete();
        exp_q.delete();
        drive();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ovalid", 64'(bus.OVALID), 64'd0);
        chk("rst_odata", 64'(bus.ODATA), 64'd0);
        chk("rst_ovch", 64'(bus.OVCH), 64'd0);
        chk("rst_gnt", 64'(bus.gnt), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(ARB_IDLE));
        chk("rst_rr", 64'(dut.rr_ptr), 64'd0);
        chk("rst_cred0", 64'(dut.credit[0]), 64'd4);
        chk("rst_cred1", 64'(dut.credit[1]), 64'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NPORT-1:0] exp_gnt [7];
        int               bad;

        // Single-flit packet on VC1, then wrap of the round-robin pointer 4 -> 0.
        do_reset();
        push_pkt(2, 1, 1, 0, 1, 1'b1);
        drive();
        step();
        chk("s1_gnt", 64'(gnt_s), 64'b00100);
        chk("s1_cred1", 64'(dut.credit[1]), 64'd3);
        chk("s1_rr", 64'(dut.rr_ptr), 64'd3);
        push_pkt(4, 0, 1, 1, 1, 1'b1);
        push_pkt(1, 0, 1, 2, 1, 1'b1);
        drive();
        step();
        chk("s1_wrap_gnt4", 64'(gnt_s), 64'b10000);
        step();
        chk("s1_wrap_gnt1", 64'(gnt_s), 64'b00010);
        flush();

        // Wormhole lock: a head bit inside port 0's packet does not re-arbitrate.
        do_reset();
        push_pkt(0, 0, 3, 0, 3, 1'b1);
        push_pkt(3, 1, 3, 1, 1, 1'b1);
        push_pkt(0, 0, 1, 2, 1, 1'b1);
        drive();
        exp_gnt = '{5'b00001, 5'b00001, 5'b00001, 5'b01000, 5'b01000, 5'b01000, 5'b00001};
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("s2_gnt%0d", k), 64'(gnt_s), 64'(exp_gnt[k]));
        end
        flush();

        // Credit exhaustion on VC0, then one returned credit re-enables the next cycle.
        do_reset();
        for (int k = 0; k < 5; k++) push_pkt(0, 0, 1, k, 1, 1'b1);
        drive();
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s3_drain_gnt", 64'(gnt_s), 64'b00001);
        end
        chk("s3_cred0_empty", 64'(dut.credit[0]), 64'd0);
        bus.IACK = 2'b01;
        step();
        chk("s3_stall_gnt", 64'(gnt_s), 64'd0);
        bus.IACK = 2'b00;
        step();
        chk("s3_resume_gnt", 64'(gnt_s), 64'b00001);
        flush();

        // Simultaneous credit return and send; overflow on a full counter.
        do_reset();
        for (int k = 0; k < 3; k++) push_pkt(0, 0, 1, k, 1, 1'b1);
        drive();
        step();
        step();
        chk("s4_cred0_two", 64'(dut.credit[0]), 64'd2);
        bus.IACK = 2'b01;
        step();
        bus.IACK = 2'b00;
        chk("s4_same_gnt", 64'(gnt_s), 64'b00001);
        chk("s4_cred0_same", 64'(dut.credit[0]), 64'd2);
        chk("s4_err_clear", 64'(bus.err), 64'd0);
        bus.IACK = 2'b10;
        step();
        bus.IACK = 2'b00;
        chk("s4_cred1_hold", 64'(dut.credit[1]), 64'd4);
        chk("s4_err_ovf", 64'(bus.err), 64'd1);
        flush();

        // Locked VC0 blocks a new head; ILCK mid-packet is ignored; stray body flit never wins.
        do_reset();
        bus.ILCK = 2'b01;
        push_pkt(4, 1, 3, 0, 1, 1'b1);
        push_pkt(1, 0, 3, 1, 1, 1'b1);
        push_pkt(2, 0, 1, 2, 0, 1'b0);
        drive();
        step();
        chk("s5_gnt_head", 64'(gnt_s), 64'b10000);
        bus.ILCK = 2'b11;
        step();
        chk("s5_gnt_body", 64'(gnt_s), 64'b10000);
        step();
        chk("s5_gnt_tail", 64'(gnt_s), 64'b10000);
        bus.ILCK = 2'b00;
        step();
        chk("s5_gnt_p1", 64'(gnt_s), 64'b00010);
        flush();
        chk("s5_stray_gnt", 64'(gnt_s), 64'd0);

        // Reset in the middle of a packet drops the lock.
        do_reset();
        push_pkt(0, 0, 3, 0, 1, 1'b0);
        drive();
        step();
        chk("s6_busy", 64'(dut.state), 64'(ARB_BUSY));
        do_reset();
        push_pkt(3, 1, 1, 1, 1, 1'b1);
        drive();
        step();
        chk("s6_new_gnt", 64'(gnt_s), 64'b01000);
        flush();

`ifdef NOC_ARB_TIMEOUT_EN
        // Owner stalls mid-packet for TIMEOUT cycles: lock is released and flagged.
        do_reset();
        push_pkt(0, 0, 3, 5, 1, 1'b0);
        exp_q.push_back(src_q[0][0]);
        push_pkt(1, 1, 1, 6, 1, 1'b1);
        drive();
        step();
        chk("tmo_head_gnt", 64'(gnt_s), 64'b00001);
        src_en[0] = 1'b0;
        drive();
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            if (gnt_s != '0) bad++;
        end
        chk("tmo_stall_gnts", 64'(bad), 64'd0);
        step();
        chk("tmo_next_gnt", 64'(gnt_s), 64'b00010);
        chk("tmo_err", 64'(bus.err), 64'd1);
        src_en[0] = 1'b1;
        drive();
        flush();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
